// File: rtl/pll_mon_pkg.sv
// PLL lock monitor shared types: per-channel state encoding and timer width helper.
// No logic, no latency; optional lock filter is PLL_MON_LOCK_FILTER_EN (used in pll_mon_ch).
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_LOST   = 2'd2,
    ST_FAIL   = 2'd3
  } pll_mon_state_t;

  // Timer counts 0..timeout-1, so $clog2(timeout) bits never wrap.
  function automatic int PLL_MON_TMR_W(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/pll_mon_ch.sv
// One PLL channel: synchroniser, optional debounce (PLL_MON_LOCK_FILTER_EN), supervisory FSM, error flag/counter.
// Lock rise to LOCKED in SYNC_STAGES+1 edges (+FILTER_LEN filtered); no backpressure, status always valid.
module pll_mon_ch
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES  = 3,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RELOCK   = 1,
  parameter int ERR_CNT_W    = 3,
  parameter int FILTER_LEN   = 8
) (
  input  logic                 clk_tb,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 ch_en,
  input  logic                 clr,
  output pll_mon_state_t       state,
  output logic                 lock_ok,
  output logic                 err_chk,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TMR_W = PLL_MON_TMR_W(LOCK_TIMEOUT);
  localparam int RLK_W = (MAX_RELOCK < 1) ? 1 : $clog2(MAX_RELOCK + 1);
  localparam logic [TMR_W-1:0]     TMO_MAX = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [RLK_W-1:0]     RLK_MAX = RLK_W'(MAX_RELOCK);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2 || LOCK_TIMEOUT < 2 || MAX_RELOCK < 0 || ERR_CNT_W < 1 || FILTER_LEN < 1)
  begin : g_bad_param
    $error("pll_mon_ch: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   lock_f;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_MON_LOCK_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN);

  logic [FLT_W-1:0] flt_cnt;

  // Rises only after FILTER_LEN consecutive high samples; any low sample drops it at once.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n)                 flt_cnt <= '0;
    else if (!lock_s)           flt_cnt <= '0;
    else if (flt_cnt != FLT_MAX) flt_cnt <= flt_cnt + 1'b1;
  end

  assign lock_f = lock_s && (flt_cnt == FLT_MAX);
`else
  assign lock_f = lock_s;
`endif

  pll_mon_state_t   state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [RLK_W-1:0] rlk_cnt, rlk_nxt;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_WAIT;
      tmr     <= '0;
      rlk_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      rlk_cnt <= rlk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    rlk_nxt   = rlk_cnt;
    if (clr || !ch_en) begin
      state_nxt = ST_WAIT;
      tmr_nxt   = '0;
      rlk_nxt   = '0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          // Lock is checked before the timeout so a same-cycle lock wins.
          if (lock_f) begin
            state_nxt = ST_LOCKED;
            tmr_nxt   = '0;
          end else if (tmr == TMO_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!lock_f) begin
            state_nxt = ST_LOST;
            tmr_nxt   = '0;
          end
        end
        ST_LOST: begin
          if (lock_f) begin
            if (rlk_cnt < RLK_MAX) begin
              state_nxt = ST_LOCKED;
              rlk_nxt   = rlk_cnt + 1'b1;
            end else begin
              state_nxt = ST_FAIL;
            end
          end else if (tmr == TMO_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        ST_FAIL: state_nxt = ST_FAIL;
        default: state_nxt = ST_WAIT;
      endcase
    end
  end

  assign lock_ok = (state == ST_LOCKED);

  // Error flag lags the state by one edge; the counter lags the flag by one more.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      err_chk <= 1'b0;
      err_cnt <= '0;
    end else if (clr) begin
      err_chk <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_chk <= (state == ST_LOST) || (state == ST_FAIL);
      if (err_chk && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor; one pll_mon_ch per input, any_err is a combinational OR of err_chk.
// Latency per channel as in pll_mon_ch (lock filter via PLL_MON_LOCK_FILTER_EN); no backpressure.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 3,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RELOCK   = 1,
  parameter int ERR_CNT_W    = 3,
  parameter int FILTER_LEN   = 8
) (
  input  logic                        clk_tb,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           pll_lock,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        clr,
  output logic [2*NUM_CH-1:0]         ch_state,
  output logic [NUM_CH-1:0]           lock_ok,
  output logic [NUM_CH-1:0]           err_chk,
  output logic [ERR_CNT_W*NUM_CH-1:0] err_cnt,
  output logic                        any_err
);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("pll_lock_monitor: NUM_CH out of range");
  end

  pll_mon_state_t ch_st [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_mon_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .MAX_RELOCK  (MAX_RELOCK),
      .ERR_CNT_W   (ERR_CNT_W),
      .FILTER_LEN  (FILTER_LEN)
    ) u_ch (
      .clk_tb  (clk_tb),
      .rst_n   (rst_n),
      .pll_lock(pll_lock[i]),
      .ch_en   (ch_en[i]),
      .clr     (clr),
      .state   (ch_st[i]),
      .lock_ok (lock_ok[i]),
      .err_chk (err_chk[i]),
      .err_cnt (err_cnt[ERR_CNT_W*i +: ERR_CNT_W])
    );

    assign ch_state[2*i +: 2] = ch_st[i];
  end

  assign any_err = |err_chk;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: cycle-exact lock/timeout sequence, vector table, reset mid-LOST.
// Build with PLL_MON_LOCK_FILTER_EN defined to run the debounce sequence instead of the unfiltered one.
module tb_pll_lock_monitor;

  localparam int NUM_CH = 2, SYNC_STAGES = 3, LOCK_TIMEOUT = 100;
  localparam int MAX_RELOCK = 1, ERR_CNT_W = 3, FILTER_LEN = 8;

  logic       clk_tb = 1'b0;
  logic       rst_n;
  logic [1:0] pll_lock, ch_en;
  logic       clr;
  logic [3:0] ch_state;
  logic [1:0] lock_ok, err_chk;
  logic [5:0] err_cnt;
  logic       any_err;

  int   checks = 0, failures = 0;
  logic seen_ok, seen_err;

  typedef struct {
    logic [1:0] lock;
    logic [1:0] en;
    logic       clr;
    int         hold;
    logic [3:0] st;
    logic [1:0] ok;
    logic [1:0] ec;
    logic [5:0] cnt;
    logic       any;
  } vec_t;

  always #5 clk_tb = ~clk_tb;

  pll_lock_monitor #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RELOCK(MAX_RELOCK), .ERR_CNT_W(ERR_CNT_W), .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock), .ch_en(ch_en), .clr(clr),
    .ch_state(ch_state), .lock_ok(lock_ok), .err_chk(err_chk), .err_cnt(err_cnt),
    .any_err(any_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_tb);
      #1;
      seen_ok  = seen_ok | lock_ok[0];
      seen_err = seen_err | err_chk[0];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(ch_state), 32'd0);
    chk({tag, "_lock_ok"}, 32'(lock_ok), 32'd0);
    chk({tag, "_err_chk"}, 32'(err_chk), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_any_err"}, 32'(any_err), 32'd0);
  endtask

`ifndef PLL_MON_LOCK_FILTER_EN
  vec_t tbl [19];
`endif

  initial begin
    rst_n = 1'b0; pll_lock = 2'b00; ch_en = 2'b00; clr = 1'b0;
    seen_ok = 1'b0; seen_err = 1'b0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;

`ifdef PLL_MON_LOCK_FILTER_EN
    ch_en = 2'b01;
    for (int g = 0; g < 2; g++) begin
      pll_lock = 2'b01; step(5);
      pll_lock = 2'b00; step(5);
    end
    chk("flt_glitch_no_lock", 32'(seen_ok), 32'd0);
    chk("flt_glitch_state", 32'(ch_state[1:0]), 32'd0);
    pll_lock = 2'b01;
    step(11);
    chk("flt_lock_edge11", 32'(lock_ok[0]), 32'd0);
    step(1);
    chk("flt_lock_edge12", 32'(lock_ok[0]), 32'd1);
    pll_lock = 2'b00;
    step(4);
    chk("flt_fall_lost", 32'(ch_state[1:0]), 32'd2);
`else
    ch_en = 2'b11;
    step(10);
    pll_lock = 2'b01;
    step(3);
    chk("lock_edge13", 32'(lock_ok[0]), 32'd0);
    step(1);
    chk("lock_edge14", 32'(lock_ok[0]), 32'd1);
    chk("lock_state14", 32'(ch_state[1:0]), 32'd1);
    step(85);
    chk("ch1_wait99", 32'(ch_state[3:2]), 32'd0);
    step(1);
    chk("ch1_fail100", 32'(ch_state[3:2]), 32'd3);
    chk("ch1_errchk100", 32'(err_chk[1]), 32'd0);
    step(1);
    chk("ch1_errchk101", 32'(err_chk[1]), 32'd1);
    chk("any_err101", 32'(any_err), 32'd1);
    step(1);
    chk("ch1_cnt102", 32'(err_cnt[5:3]), 32'd1);
    step(6);
    chk("ch1_cnt108", 32'(err_cnt[5:3]), 32'd7);
    step(12);
    chk("ch1_cnt_sat", 32'(err_cnt[5:3]), 32'd7);
    chk("ch0_no_err", 32'(seen_err), 32'd0);

    //            lock   en     clr   hold st       ok     ec     cnt    any
    tbl[0]  = '{2'b01, 2'b01, 1'b0, 2,  4'b0001, 2'b01, 2'b00, 6'o70, 1'b0};
    tbl[1]  = '{2'b00, 2'b01, 1'b0, 3,  4'b0001, 2'b01, 2'b00, 6'o70, 1'b0};
    tbl[2]  = '{2'b00, 2'b01, 1'b0, 1,  4'b0010, 2'b00, 2'b00, 6'o70, 1'b0};
    tbl[3]  = '{2'b00, 2'b01, 1'b0, 1,  4'b0010, 2'b00, 2'b01, 6'o70, 1'b1};
    tbl[4]  = '{2'b00, 2'b01, 1'b0, 1,  4'b0010, 2'b00, 2'b01, 6'o71, 1'b1};
    tbl[5]  = '{2'b00, 2'b01, 1'b0, 14, 4'b0010, 2'b00, 2'b01, 6'o77, 1'b1};
    tbl[6]  = '{2'b01, 2'b01, 1'b0, 3,  4'b0010, 2'b00, 2'b01, 6'o77, 1'b1};
    tbl[7]  = '{2'b01, 2'b01, 1'b0, 1,  4'b0001, 2'b01, 2'b01, 6'o77, 1'b1};
    tbl[8]  = '{2'b01, 2'b01, 1'b0, 1,  4'b0001, 2'b01, 2'b00, 6'o77, 1'b0};
    tbl[9]  = '{2'b00, 2'b01, 1'b0, 4,  4'b0010, 2'b00, 2'b00, 6'o77, 1'b0};
    tbl[10] = '{2'b01, 2'b01, 1'b0, 4,  4'b0011, 2'b00, 2'b01, 6'o77, 1'b1};
    tbl[11] = '{2'b01, 2'b01, 1'b0, 10, 4'b0011, 2'b00, 2'b01, 6'o77, 1'b1};
    tbl[12] = '{2'b01, 2'b01, 1'b1, 1,  4'b0000, 2'b00, 2'b00, 6'o00, 1'b0};
    tbl[13] = '{2'b01, 2'b01, 1'b0, 1,  4'b0001, 2'b01, 2'b00, 6'o00, 1'b0};
    tbl[14] = '{2'b00, 2'b01, 1'b0, 4,  4'b0010, 2'b00, 2'b00, 6'o00, 1'b0};
    tbl[15] = '{2'b00, 2'b01, 1'b0, 3,  4'b0010, 2'b00, 2'b01, 6'o02, 1'b1};
    tbl[16] = '{2'b00, 2'b00, 1'b0, 1,  4'b0000, 2'b00, 2'b01, 6'o03, 1'b1};
    tbl[17] = '{2'b00, 2'b01, 1'b0, 1,  4'b0000, 2'b00, 2'b00, 6'o04, 1'b0};
    tbl[18] = '{2'b00, 2'b01, 1'b0, 1,  4'b0000, 2'b00, 2'b00, 6'o04, 1'b0};

    for (int i = 0; i < 19; i++) begin
      pll_lock = tbl[i].lock;
      ch_en    = tbl[i].en;
      clr      = tbl[i].clr;
      step(tbl[i].hold);
      chk($sformatf("row%0d_state", i), 32'(ch_state), 32'(tbl[i].st));
      chk($sformatf("row%0d_lock_ok", i), 32'(lock_ok), 32'(tbl[i].ok));
      chk($sformatf("row%0d_err_chk", i), 32'(err_chk), 32'(tbl[i].ec));
      chk($sformatf("row%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_any_err", i), 32'(any_err), 32'(tbl[i].any));
    end
    clr = 1'b0;

    pll_lock = 2'b01;
    step(4);
    chk("rst_pre_locked", 32'(ch_state[1:0]), 32'd1);
    pll_lock = 2'b00;
    step(4);
    chk("rst_pre_lost", 32'(ch_state[1:0]), 32'd2);
    step(2);
    chk("rst_pre_cnt5", 32'(err_cnt[2:0]), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_lost");
    #2;
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Multi-channel PLL lock supervisor for the clocking subsystem's IP-level benches and bring-up builds. Synchronises up to NUM_CH raw `pll_lock` signals into the `clk_tb` domain. Runs one supervisory state machine per channel covering initial-lock timeout, lock loss and bounded relock. Reports per-channel status, registered error flags and saturating error counters, replacing ad-hoc lock-pulse checkers with one reusable block.

## Interface
- NUM_CH, 4: number of monitored PLLs (1..16).
- SYNC_STAGES, 3: synchroniser depth per channel (≥2).
- LOCK_TIMEOUT, 50000: max `clk_tb` cycles allowed in WAIT or LOST before FAIL (≥2).
- MAX_RELOCK, 1: relocks tolerated per enable session; the next relock attempt beyond this fails.
- ERR_CNT_W, 3: per-channel error counter width.
- FILTER_LEN, 8: lock debounce length, used only with the filter macro.
- clk_tb  in  1  monitor clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pll_lock  in  NUM_CH  raw asynchronous lock inputs.
- ch_en  in  NUM_CH  channel enable, synchronous to `clk_tb`.
- clr  in  1  synchronous clear of all state and counters.
- ch_state  out  2*NUM_CH  per-channel state; channel i occupies [2i+1:2i].
- lock_ok  out  NUM_CH  high while the channel is in LOCKED.
- err_chk  out  NUM_CH  registered error flag.
- err_cnt  out  ERR_CNT_W*NUM_CH  saturating error counters.
- any_err  out  1  OR of `err_chk`.

## Operation
- Synchroniser: SYNC_STAGES flops per channel, reset 0. The last stage is `lock_s`.
- `lock_f` is `lock_s`, or the filtered version when the filter macro is enabled (see Configuration).
- States: WAIT=0, LOCKED=1, LOST=2, FAIL=3.
- WAIT:
  - `lock_f`=1 → LOCKED; timer cleared.
  - Otherwise timer increments; when timer = LOCK_TIMEOUT-1 → FAIL.
- LOCKED:
  - `lock_f`=0 → LOST; timer cleared.
- LOST:
  - `lock_f`=1 with relock_cnt < MAX_RELOCK → LOCKED; relock_cnt increments.
  - `lock_f`=1 with relock_cnt = MAX_RELOCK → FAIL.
  - Otherwise timer increments; timeout behaves as in WAIT.
- FAIL: sticky until `clr` or `ch_en`=0.
- Timer width is $clog2(LOCK_TIMEOUT). The timer never wraps.
- `ch_en`=0: state WAIT, timer 0, relock_cnt 0, `err_cnt` retained. The timer does not run while disabled.
- `clr`: all channels go to WAIT; timer, relock_cnt, `err_chk` and `err_cnt` go to 0.
- Priority order: `clr` > `ch_en`=0 > FSM transition.
- `err_chk[i]` is registered as (state ∈ {LOST, FAIL}).
- `err_cnt[i]` increments on every cycle `err_chk[i]`=1 and saturates at 2^ERR_CNT_W-1; it never wraps.
- `lock_ok` and `ch_state` decode directly from the state register; there is no extra latency.
- Reset values: `ch_state`=WAIT, `lock_ok`=0, `err_chk`=0, `err_cnt`=0, `any_err`=0. Synchroniser and filter flops are 0.
- Reset asserted mid-operation drops everything to these values immediately, with no residual error count.

## Timing
- `pll_lock` rise to `lock_ok` rise: SYNC_STAGES+1 edges, plus FILTER_LEN with the filter enabled.
- `pll_lock` fall to `ch_state`=LOST: SYNC_STAGES+1 edges. The filter adds no delay on falls.
- State change to `err_chk`: 1 edge. `err_chk` to `err_cnt` increment: 1 edge.
- `any_err` is combinational from the `err_chk` flops.
- WAIT timeout: FAIL is entered on the LOCK_TIMEOUT-th enabled WAIT cycle.
- Lock and timeout on the same cycle: lock wins.

## Configuration
- PLL_MON_LOCK_FILTER_EN defined:
  - Per-channel debounce counter (width $clog2(FILTER_LEN+1)).
  - `lock_f` rises only after `lock_s` has been 1 for FILTER_LEN consecutive cycles.
  - `lock_f` falls, and the counter clears, on the first `lock_s`=0.
- Macro undefined: `lock_f`=`lock_s`, no filter flops, FILTER_LEN unused.

## Structure
- Package `pll_mon_pkg`: state enum `pll_mon_state_t` (2-bit), the state encodings, and a `PLL_MON_TMR_W(timeout)` width helper.
- Sub-module `pll_mon_ch`: one channel containing the synchroniser, optional filter, FSM, timer, relock counter, `err_chk` and `err_cnt`.
- Top level: generate loop over NUM_CH plus the `any_err` reduction.

## Test plan
Default bench parameters: NUM_CH=2, SYNC_STAGES=3, LOCK_TIMEOUT=100, MAX_RELOCK=1, ERR_CNT_W=3.

- Clean lock:
  - Stimulus: rst_n released, `ch_en`=2'b11, `pll_lock[0]` rises at cycle 10.
  - Response: `lock_ok[0]`=1 at cycle 14; `err_chk`=0 throughout; `pll_lock[1]` held low, so ch1 reaches FAIL at cycle 100 and `err_cnt[1]` saturates at 7.
- Single relock:
  - Stimulus: ch0 locked, `pll_lock[0]` low for 20 cycles, then high.
  - Response: LOST after 4 edges, `err_chk[0]`=1 for the 20-cycle LOST window (counter saturates at 7), return to LOCKED, relock_cnt=1.
- Second loss:
  - Stimulus: after the relock, `pll_lock[0]` drops again, then returns.
  - Response: FAIL on return; FAIL persists after `pll_lock[0]` stays high; `any_err`=1.
- Recovery:
  - Stimulus: `clr` pulsed for 1 cycle during FAIL.
  - Response: WAIT, `err_cnt`=0, `err_chk`=0 next cycle.
  - Stimulus: `ch_en[0]`=0 for 1 cycle.
  - Response: WAIT with `err_cnt[0]` retained.
- Filter (macro defined, FILTER_LEN=8):
  - Stimulus: 5-cycle lock glitches on `pll_lock[0]`.
  - Response: `lock_ok` stays 0.
  - Stimulus: steady high.
  - Response: `lock_ok` rises 12 edges after `pll_lock`.
- Reset mid-LOST:
  - Stimulus: `rst_n` asserted while ch0 is in LOST with `err_cnt`=5.
  - Response: all outputs 0 / WAIT immediately, with no clock edge required.
